// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: latches the decoded ID instruction, its operands and
// forwarding flags for EX, inserts NOP bubbles on load-use stall or redirect
// flush, and keeps saturating performance counters.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              id_aluaeq,
  input  logic              id_alubeq,
  input  logic              id_memaeq,
  input  logic              id_membeq,
  input  logic              id_rfd2alueq,
  input  logic              id_rfd2dmeq,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [31:0]       ex_instr,
  output logic [5:0]        ex_op,
  output logic [5:0]        ex_funct,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_shamt,
  output logic [31:0]       ex_imm,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic              ex_aluaeq,
  output logic              ex_alubeq,
  output logic              ex_memaeq,
  output logic              ex_membeq,
  output logic              ex_rfd2alueq,
  output logic              ex_rfd2dmeq,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 32;
  localparam int unsigned HALF_W  = 16;

  // Logical-immediate opcodes take a zero-extended immediate.
  localparam logic [OP_W-1:0] OP_ANDI = 6'h0c;
  localparam logic [OP_W-1:0] OP_ORI  = 6'h0d;
  localparam logic [OP_W-1:0] OP_XORI = 6'h0e;

  // Everything that travels from ID into EX; all-zero is a NOP bubble.
  typedef struct packed {
    logic                valid;
    logic [DATA_W-1:0]   pc;
    logic [INSTR_W-1:0]  instr;
    logic [OP_W-1:0]     op;
    logic [OP_W-1:0]     funct;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    shamt;
    logic [IMM_W-1:0]    imm;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic                aluaeq;
    logic                alubeq;
    logic                memaeq;
    logic                membeq;
    logic                rfd2alueq;
    logic                rfd2dmeq;
  } ex_payload_t;

  ex_payload_t payload_q, payload_d;
  ex_payload_t load_payload;

  logic [CNT_W-1:0] instr_cnt_q,  instr_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

  logic [OP_W-1:0] id_op;
  logic            zero_ext;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign id_op    = id_instr[31:26];
  assign zero_ext = (id_op == OP_ANDI) || (id_op == OP_ORI) || (id_op == OP_XORI);

  // Decode the ID instruction into the payload EX would receive on a load.
  always_comb begin
    load_payload           = '0;
    load_payload.valid     = 1'b1;
    load_payload.pc        = id_pc;
    load_payload.instr     = id_instr;
    load_payload.op        = id_op;
    load_payload.rs        = id_instr[25:21];
    load_payload.rt        = id_instr[20:16];
    load_payload.rd        = id_instr[15:11];
    load_payload.shamt     = id_instr[10:6];
    load_payload.funct     = id_instr[5:0];
    if (zero_ext) begin
      load_payload.imm = {{(IMM_W-HALF_W){1'b0}}, id_instr[15:0]};
    end else begin
      load_payload.imm = {{(IMM_W-HALF_W){id_instr[15]}}, id_instr[15:0]};
    end
    load_payload.rs_data   = id_rs_data;
    load_payload.rt_data   = id_rt_data;
    load_payload.aluaeq    = id_aluaeq;
    load_payload.alubeq    = id_alubeq;
    load_payload.memaeq    = id_memaeq;
    load_payload.membeq    = id_membeq;
    load_payload.rfd2alueq = id_rfd2alueq;
    load_payload.rfd2dmeq  = id_rfd2dmeq;
  end

  // Next-state selection: hold, flush bubble, stall bubble or load.
  always_comb begin
    payload_d    = payload_q;
    instr_cnt_d  = instr_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (en) begin
      if (flush) begin
        // A flush overrides a simultaneous stall and counts only as a flush.
        payload_d   = '0;
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (stall) begin
        payload_d    = '0;
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end else if (id_valid) begin
        payload_d   = load_payload;
        instr_cnt_d = sat_inc(instr_cnt_q);
      end else begin
        // Empty ID slot: clear so hazard logic never sees stale fields.
        payload_d = '0;
      end
    end
  end

  // Stage register and counters with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      payload_q    <= '0;
      instr_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      payload_q    <= payload_d;
      instr_cnt_q  <= instr_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_valid     = payload_q.valid;
  assign ex_pc        = payload_q.pc;
  assign ex_instr     = payload_q.instr;
  assign ex_op        = payload_q.op;
  assign ex_funct     = payload_q.funct;
  assign ex_rs        = payload_q.rs;
  assign ex_rt        = payload_q.rt;
  assign ex_rd        = payload_q.rd;
  assign ex_shamt     = payload_q.shamt;
  assign ex_imm       = payload_q.imm;
  assign ex_rs_data   = payload_q.rs_data;
  assign ex_rt_data   = payload_q.rt_data;
  assign ex_aluaeq    = payload_q.aluaeq;
  assign ex_alubeq    = payload_q.alubeq;
  assign ex_memaeq    = payload_q.memaeq;
  assign ex_membeq    = payload_q.membeq;
  assign ex_rfd2alueq = payload_q.rfd2alueq;
  assign ex_rfd2dmeq  = payload_q.rfd2dmeq;
  assign instr_cnt    = instr_cnt_q;
  assign bubble_cnt   = bubble_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule
